// File: rtl/data_path.sv
// data_path: 32-bit single-bus datapath for a microcoded CPU.
// Registers R0-R15, PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO and a 5-bit-opcode ALU.
// Every transfer goes over one combinational bus, steered by external strobes.
// Optional feature macro: ALU_MULDIV_EN. When it is defined, the signed multiply
// (10000) and divide (01111) opcodes are implemented. When it is undefined, both
// opcodes yield C=0 and no multiplier or divider is built.
// There is no FSM here: the microcode sequencer lives outside this block.
module data_path (
  input  logic        clock,
  input  logic        clear,
  input  logic        PCout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        R0out,
  input  logic        R1out,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  input  logic        Cin,
  input  logic        MARin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        R0in,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        R6in,
  input  logic        R7in,
  input  logic        R8in,
  input  logic        R9in,
  input  logic        R10in,
  input  logic        R11in,
  input  logic        R12in,
  input  logic        R13in,
  input  logic        R14in,
  input  logic        R15in,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHighIn,
  input  logic        ZLowIn,
  input  logic        IncPC,
  input  logic        Read,
  input  logic [4:0]  opcode,
  input  logic [31:0] Mdatain,
  output logic [31:0] BusMuxOut,
  output logic [31:0] IRq,
  output logic [31:0] MARq
);

  // Handshake note: there is no valid/ready protocol here. Every load enable is
  // a one-cycle strobe that takes effect at the next rising clock edge, and the
  // bus settles combinationally within the cycle the select is held.

  // Opcode encodings
  localparam logic [4:0] OP_ADD0 = 5'b00000;
  localparam logic [4:0] OP_ADD1 = 5'b00001;
  localparam logic [4:0] OP_ADD2 = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // Gather the per-register strobes into vectors so they can be looped over.
  logic [7:0]  r_out;
  logic [15:0] r_in;
  assign r_out = {R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

  // State registers and their next-state values
  logic [31:0] r_q [16];
  logic [31:0] r_d [16];
  logic [31:0] pc_q,  pc_d;
  logic [31:0] ir_q,  ir_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] y_q,   y_d;
  logic [63:0] z_q,   z_d;
  logic [31:0] hi_q,  hi_d;
  logic [31:0] lo_q,  lo_d;

  logic [31:0] bus;
  logic [31:0] c_ext;
  logic [63:0] alu_c;

  // The constant source is IR[18:0] sign-extended to 32 bits.
  assign c_ext = {{13{ir_q[18]}}, ir_q[18:0]};

  // Bus mux: later assignments override earlier ones, so the list runs from
  // lowest priority (Cin) to highest (R0out).
  always_comb begin
    bus = 32'h0;
    if (Cin)      bus = c_ext;
    if (Zlowout)  bus = z_q[31:0];
    if (Zhighout) bus = z_q[63:32];
    if (MDRout)   bus = mdr_q;
    if (PCout)    bus = pc_q;
    for (int i = 7; i >= 0; i--) begin
      if (r_out[i]) bus = r_q[i];
    end
  end

  // ALU: A is Y, B is the bus. The shift count is A[4:0] only.
  logic [31:0] alu_a, alu_b;
  logic [4:0]  sh;
  logic [63:0] dbl, ror_w, rol_w;
  assign alu_a = y_q;
  assign alu_b = bus;
  assign sh    = y_q[4:0];
  assign dbl   = {alu_b, alu_b};
  assign ror_w = dbl >> sh;
  assign rol_w = dbl << sh;

`ifdef ALU_MULDIV_EN
  logic signed [31:0] a_s, b_s;
  logic signed [63:0] a_x, b_x;
  assign a_s = $signed(alu_a);
  assign b_s = $signed(alu_b);
  assign a_x = $signed({{32{alu_a[31]}}, alu_a});
  assign b_x = $signed({{32{alu_b[31]}}, alu_b});
`endif

  // ALU operation select; the upper half of C is zero except for mul/div.
  always_comb begin
    alu_c = 64'h0;
    case (opcode)
      OP_ADD0, OP_ADD1, OP_ADD2, OP_ADD, OP_ADDI:
                     alu_c[31:0] = alu_a + alu_b;
      OP_SUB:        alu_c[31:0] = alu_a - alu_b;
      OP_AND, OP_ANDI:
                     alu_c[31:0] = alu_a & alu_b;
      OP_OR, OP_ORI: alu_c[31:0] = alu_a | alu_b;
      OP_ROR:        alu_c[31:0] = ror_w[31:0];
      OP_ROL:        alu_c[31:0] = rol_w[63:32];
      OP_SHR:        alu_c[31:0] = alu_b >> sh;
      OP_SHRA:       alu_c[31:0] = 32'($signed(alu_b) >>> sh);
      OP_SHL:        alu_c[31:0] = alu_b << sh;
`ifdef ALU_MULDIV_EN
      OP_DIV: begin
        if (alu_b != 32'h0) begin
          alu_c[31:0]  = 32'(a_s / b_s);
          alu_c[63:32] = 32'(a_s % b_s);
        end
      end
      OP_MUL:        alu_c = 64'(a_x * b_x);
`else
      OP_DIV, OP_MUL: alu_c = 64'h0;
`endif
      OP_NEG:        alu_c[31:0] = 32'h0 - alu_b;
      OP_NOT:        alu_c[31:0] = ~alu_b;
      default:       alu_c = 64'h0;
    endcase
  end

  // Next-state logic: each register holds unless its enable is set.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      r_d[i] = r_in[i] ? bus : r_q[i];
    end
    if (PCin)       pc_d = bus;
    else if (IncPC) pc_d = pc_q + 32'd1;
    else            pc_d = pc_q;
    ir_d  = IRin  ? bus : ir_q;
    mar_d = MARin ? bus : mar_q;
    mdr_d = MDRin ? (Read ? Mdatain : bus) : mdr_q;
    y_d   = Yin   ? bus : y_q;
    hi_d  = HIin  ? bus : hi_q;
    lo_d  = LOin  ? bus : lo_q;
    z_d[63:32] = ZHighIn ? alu_c[63:32] : z_q[63:32];
    z_d[31:0]  = ZLowIn  ? alu_c[31:0]  : z_q[31:0];
  end

  // State update with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= 32'h0;
      pc_q  <= 32'h0;
      ir_q  <= 32'h0;
      mar_q <= 32'h0;
      mdr_q <= 32'h0;
      y_q   <= 32'h0;
      z_q   <= 64'h0;
      hi_q  <= 32'h0;
      lo_q  <= 32'h0;
    end else begin
      for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign BusMuxOut = bus;
  assign IRq       = ir_q;
  assign MARq      = mar_q;

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed bench for data_path. An ALU vector table plus
// hand-written multi-cycle sequences for reset, MDR/PC/IR paths and priority.
module tb_data_path;

  logic        clock;
  logic        clear;
  logic        PCout, Zhighout, Zlowout, MDRout, Cin;
  logic [7:0]  rout;
  logic [15:0] rin;
  logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn;
  logic        IncPC, Read;
  logic [4:0]  opcode;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut, IRq, MARq;

  int n_vec;
  int n_err;

  data_path dut (
    .clock(clock), .clear(clear),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .Cin(Cin),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .IncPC(IncPC), .Read(Read), .opcode(opcode), .Mdatain(Mdatain),
    .BusMuxOut(BusMuxOut), .IRq(IRq), .MARq(MARq)
  );

  // Clock generation
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } alu_vec_t;

  localparam int NV = 25;
  alu_vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    clear = 1'b1;
    PCout = 0; Zhighout = 0; Zlowout = 0; MDRout = 0; Cin = 0;
    rout = '0; rin = '0;
    MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; HIin = 0; LOin = 0;
    ZHighIn = 0; ZLowIn = 0; IncPC = 0; Read = 0;
    opcode = 5'b0; Mdatain = 32'h0;
  endtask

  // One clock edge with the currently driven controls, then back to idle.
  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic mem_to_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
  endtask

  task automatic load_reg(input int idx, input logic [31:0] v);
    mem_to_mdr(v);
    MDRout = 1; rin[idx] = 1;
    tick();
  endtask

  task automatic load_y(input logic [31:0] v);
    mem_to_mdr(v);
    MDRout = 1; Yin = 1;
    tick();
  endtask

  task automatic chk_reg(input string name, input int idx, input logic [31:0] exp);
    rout[idx] = 1;
    #1;
    chk(name, BusMuxOut, exp);
    rout[idx] = 0;
  endtask

  task automatic chk_pc(input string name, input logic [31:0] exp);
    PCout = 1; #1; chk(name, BusMuxOut, exp); PCout = 0;
  endtask

  task automatic chk_zlo(input string name, input logic [31:0] exp);
    Zlowout = 1; #1; chk(name, BusMuxOut, exp); Zlowout = 0;
  endtask

  task automatic chk_zhi(input string name, input logic [31:0] exp);
    Zhighout = 1; #1; chk(name, BusMuxOut, exp); Zhighout = 0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // ALU table: {opcode, A(Y), B(bus), expected Z[31:0], expected Z[63:32]}
    vecs[0]  = '{5'b00011, 32'd5,        32'd7,        32'd12,       32'h0};
    vecs[1]  = '{5'b00100, 32'd3,        32'd5,        32'hFFFFFFFE, 32'h0};
    vecs[2]  = '{5'b00100, 32'h80000000, 32'd1,        32'h7FFFFFFF, 32'h0};
    vecs[3]  = '{5'b00101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0};
    vecs[4]  = '{5'b00110, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 32'h0};
    vecs[5]  = '{5'b00111, 32'd4,        32'h12345678, 32'h81234567, 32'h0};
    vecs[6]  = '{5'b01000, 32'd8,        32'h12345678, 32'h34567812, 32'h0};
    vecs[7]  = '{5'b01001, 32'd4,        32'h80000000, 32'h08000000, 32'h0};
    vecs[8]  = '{5'b01010, 32'd4,        32'h80000000, 32'hF8000000, 32'h0};
    vecs[9]  = '{5'b01011, 32'd4,        32'h0000000F, 32'h000000F0, 32'h0};
    vecs[10] = '{5'b00111, 32'h20,       32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vecs[11] = '{5'b01011, 32'h3F,       32'd1,        32'h80000000, 32'h0};
    vecs[12] = '{5'b00000, 32'd1,        32'd2,        32'd3,        32'h0};
    vecs[13] = '{5'b01100, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0};
    vecs[14] = '{5'b01101, 32'h0F0F,     32'h00FF,     32'h000F,     32'h0};
    vecs[15] = '{5'b01110, 32'h0F00,     32'h00F0,     32'h0FF0,     32'h0};
    vecs[16] = '{5'b10001, 32'h1234,     32'd1,        32'hFFFFFFFF, 32'h0};
    vecs[17] = '{5'b10010, 32'h1234,     32'h0000FFFF, 32'hFFFF0000, 32'h0};
    vecs[18] = '{5'b10011, 32'd5,        32'd7,        32'h0,        32'h0};
    vecs[19] = '{5'b11111, 32'd5,        32'd7,        32'h0,        32'h0};
`ifdef ALU_MULDIV_EN
    vecs[20] = '{5'b01111, 32'd7,        32'd2,        32'd3,        32'd1};
    vecs[21] = '{5'b01111, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[22] = '{5'b01111, 32'd7,        32'd0,        32'h0,        32'h0};
    vecs[23] = '{5'b10000, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'hFFFFFFFF};
    vecs[24] = '{5'b10000, 32'h00010000, 32'h00010000, 32'h0,        32'd1};
`else
    vecs[20] = '{5'b01111, 32'd7,        32'd2,        32'h0,        32'h0};
    vecs[21] = '{5'b01111, 32'hFFFFFFF9, 32'd2,        32'h0,        32'h0};
    vecs[22] = '{5'b01111, 32'd7,        32'd0,        32'h0,        32'h0};
    vecs[23] = '{5'b10000, 32'hFFFFFFFF, 32'd2,        32'h0,        32'h0};
    vecs[24] = '{5'b10000, 32'h00010000, 32'h00010000, 32'h0,        32'h0};
`endif

    // Power-up reset
    idle();
    clear = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    idle();

    // Arbitrary loads, then a clear edge while loads are also requested
    load_reg(3, 32'h0000AAAA);
    load_reg(0, 32'h00001234);
    load_y(32'd5);
    mem_to_mdr(32'h00070099);
    MDRout = 1; PCin = 1; MARin = 1; IRin = 1; opcode = 5'b00011;
    ZLowIn = 1; ZHighIn = 1;
    tick();
    clear = 1'b0; Mdatain = 32'hFFFF0000; Read = 1; MDRin = 1; Yin = 1;
    tick();
    chk("rst_ir", IRq, 32'h0);
    chk("rst_mar", MARq, 32'h0);
    #1; chk("rst_bus_idle", BusMuxOut, 32'h0);
    for (int i = 0; i < 8; i++) chk_reg($sformatf("rst_r%0d", i), i, 32'h0);
    chk_pc("rst_pc", 32'h0);
    MDRout = 1; #1; chk("rst_mdr", BusMuxOut, 32'h0); MDRout = 0;
    chk_zhi("rst_zhi", 32'h0);
    chk_zlo("rst_zlo", 32'h0);
    Cin = 1; #1; chk("rst_cin", BusMuxOut, 32'h0); Cin = 0;
    // Y is observed through Z = Y + 0
    opcode = 5'b00011; ZLowIn = 1; tick();
    chk_zlo("rst_y", 32'h0);

    // MDR from memory, then into R4
    mem_to_mdr(32'h12);
    MDRout = 1; rin[4] = 1; tick();
    chk_reg("mdr_to_r4", 4, 32'h12);

    // shra through Y and Z into R4
    load_reg(3, 32'h7F);
    load_reg(7, 32'd2);
    rout[7] = 1; Yin = 1; tick();
    rout[3] = 1; opcode = 5'b01010; ZLowIn = 1; tick();
    Zlowout = 1; rin[4] = 1; tick();
    chk_reg("shra_r4", 4, 32'h1F);

    // PC load, then PC to MAR with increment in the same edge
    mem_to_mdr(32'd7);
    MDRout = 1; PCin = 1; tick();
    PCout = 1; MARin = 1; IncPC = 1; tick();
    chk("pc_mar", MARq, 32'd7);
    chk_pc("pc_inc", 32'd8);
    // PCin wins over IncPC
    mem_to_mdr(32'h100);
    MDRout = 1; PCin = 1; IncPC = 1; tick();
    chk_pc("pc_prio", 32'h100);
    // Increment wraps
    mem_to_mdr(32'hFFFFFFFF);
    MDRout = 1; PCin = 1; tick();
    IncPC = 1; tick();
    chk_pc("pc_wrap", 32'h0);

    // IR load and sign-extended constant
    mem_to_mdr(32'h00040001);
    MDRout = 1; IRin = 1; tick();
    chk("ir_load", IRq, 32'h00040001);
    Cin = 1; #1; chk("cin_neg", BusMuxOut, 32'hFFFC0001); Cin = 0;
    mem_to_mdr(32'hFFF3FFFF);
    MDRout = 1; IRin = 1; tick();
    Cin = 1; #1; chk("cin_pos", BusMuxOut, 32'h0003FFFF); Cin = 0;

    // Bus priority
    load_reg(1, 32'h11);
    load_reg(2, 32'h22);
    mem_to_mdr(32'h33);
    rout[1] = 1; rout[2] = 1; #1; chk("prio_r1_r2", BusMuxOut, 32'h11); idle();
    rout[2] = 1; PCout = 1; #1; chk("prio_r2_pc", BusMuxOut, 32'h22); idle();
    PCout = 1; MDRout = 1; #1; chk("prio_pc_mdr", BusMuxOut, 32'h0); idle();
    MDRout = 1; Zlowout = 1; Cin = 1; #1; chk("prio_mdr_z", BusMuxOut, 32'h33); idle();

    // Same-cycle read and write: R1 captures the old MDR, MDR takes new data
    MDRout = 1; rin[1] = 1; MDRin = 1; Read = 1; Mdatain = 32'h44;
    #1; chk("rw_bus_old", BusMuxOut, 32'h33);
    tick();
    chk_reg("rw_r1_old", 1, 32'h33);
    MDRout = 1; #1; chk("rw_mdr_new", BusMuxOut, 32'h44); idle();
    // MDR loaded from the bus when Read=0
    rout[2] = 1; MDRin = 1; tick();
    MDRout = 1; #1; chk("mdr_from_bus", BusMuxOut, 32'h22); idle();

    // ALU table
    for (int i = 0; i < NV; i++) begin
      load_y(vecs[i].a);
      mem_to_mdr(vecs[i].b);
      MDRout = 1; opcode = vecs[i].op; ZLowIn = 1; ZHighIn = 1;
      tick();
      chk_zlo($sformatf("alu%0d_lo", i), vecs[i].lo);
      chk_zhi($sformatf("alu%0d_hi", i), vecs[i].hi);
    end

    // ZLowIn alone leaves Z[63:32] alone
    load_y(32'd1);
    mem_to_mdr(32'hFFFFFFFF);
    MDRout = 1; opcode = 5'b10010; ZHighIn = 1; ZLowIn = 1; tick();
    load_y(32'd2);
    mem_to_mdr(32'd3);
    MDRout = 1; opcode = 5'b00011; ZLowIn = 1; tick();
    chk_zlo("zlo_only_lo", 32'd5);
    chk_zhi("zlo_only_hi", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
